// File: rtl/fmeter_pkg.sv
// rtl/fmeter_pkg.sv - shared constants, state enums and digit encoding for the BCD UART reporter
package fmeter_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_BAD  = 8'h3F;

    // SKIP can burn up to eight cycles inside the first start bit, so keep BAUD_DIV >= 10.
    localparam int BAUD_DIV_DEFAULT = 1736;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        START,
        DATA,
        STOP,
        NEXT
    } rep_state_t;

    typedef enum logic [1:0] {
        SEL_DIGIT,
        SEL_CR,
        SEL_LF,
        SEL_END
    } char_sel_t;

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (ASCII_ZERO + {4'd0, d}) : ASCII_BAD;
    endfunction

endpackage

// File: rtl/bcd_uart_reporter_if.sv
// rtl/bcd_uart_reporter_if.sv - byte/start/done handshake between character sequencer and serializer
interface bcd_uart_reporter_if;

    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_bit_end;
    logic [3:0] tx_bit_idx;
    logic       tx_done;

    // tx_byte is sampled at the end of the start bit, not at tx_start.
    modport master (
        output tx_byte,
        output tx_start,
        input  tx_bit_end,
        input  tx_bit_idx,
        input  tx_done
    );

    modport slave (
        input  tx_byte,
        input  tx_start,
        output tx_bit_end,
        output tx_bit_idx,
        output tx_done
    );

endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with baud counter, bit counter and shift register
module uart_tx_byte
    import fmeter_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    bcd_uart_reporter_if.slave         tx,
    output logic                       txd
);

    localparam int CW = $clog2(BAUD_DIV);

    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          busy_q, busy_d;
    logic          txd_q, txd_d;
    logic          bit_end;

    assign bit_end       = busy_q && (baud_cnt_q == CW'(BAUD_DIV - 1));
    assign tx.tx_bit_end = bit_end;
    assign tx.tx_bit_idx = bit_idx_q;
    assign tx.tx_done    = bit_end && (bit_idx_q == 4'd9);
    assign txd           = txd_q;

    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        busy_d     = busy_q;
        txd_d      = txd_q;

        if (busy_q) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + CW'(1);
            if (bit_end) begin
                bit_idx_d = bit_idx_q + 4'd1;
                if (bit_idx_q == 4'd0) begin
                    txd_d   = tx.tx_byte[0];
                    shift_d = {1'b1, tx.tx_byte[7:1]};
                end else if (bit_idx_q == 4'd9) begin
                    busy_d    = 1'b0;
                    txd_d     = 1'b1;
                    bit_idx_d = '0;
                end else begin
                    // Ones shifted in from the top become the stop bit after data bit 7.
                    txd_d   = shift_q[0];
                    shift_d = {1'b1, shift_q[7:1]};
                end
            end
        end

        // A start during the final stop cycle chains the next frame with no idle gap.
        if (tx.tx_start && (!busy_q || tx.tx_done)) begin
            busy_d     = 1'b1;
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            txd_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            busy_q     <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            busy_q     <= busy_d;
            txd_q      <= txd_d;
        end
    end

endmodule

// File: rtl/bcd_uart_reporter.sv
// rtl/bcd_uart_reporter.sv - sends each accepted 8-digit BCD value as an ASCII line over a UART
module bcd_uart_reporter
    import fmeter_pkg::*;
#(
    parameter int BAUD_DIV    = BAUD_DIV_DEFAULT,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic        CLK100MHz,
    input  logic        RST_N,
    input  logic [31:0] BCD_IN,
    input  logic        BCD_VALID,
    output logic        BCD_READY,
    output logic        TXD,
    output logic        DROPPED
);

    rep_state_t  state_q, state_d;
    char_sel_t   sel_q, sel_d;
    logic [31:0] digits_q, digits_d;
    logic [2:0]  digit_idx_q, digit_idx_d;
    logic        ready_q, ready_d;
    logic        dropped_q, dropped_d;

    logic [3:0]  cur_digit;
    logic        accept;
    logic [7:0]  tx_byte;
    logic        tx_start;

    bcd_uart_reporter_if tx_if ();

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk   (CLK100MHz),
        .rst_n (RST_N),
        .tx    (tx_if.slave),
        .txd   (TXD)
    );

    assign cur_digit      = digits_q[{digit_idx_q, 2'b00} +: 4];
    assign accept         = BCD_VALID && ready_q;
    assign tx_if.tx_byte  = tx_byte;
    assign tx_if.tx_start = tx_start;
    assign BCD_READY      = ready_q;
    assign DROPPED        = dropped_q;

    always_comb begin
        tx_byte = ASCII_LF;
        case (sel_q)
            SEL_DIGIT: tx_byte = digit_to_ascii(cur_digit);
            SEL_CR:    tx_byte = ASCII_CR;
            default:   tx_byte = ASCII_LF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        digits_d    = digits_q;
        digit_idx_d = digit_idx_q;
        ready_d     = ready_q;
        dropped_d   = BCD_VALID && !ready_q;
        tx_start    = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    digits_d    = BCD_IN;
                    digit_idx_d = 3'd7;
                    sel_d       = SEL_DIGIT;
                    ready_d     = 1'b0;
                    tx_start    = 1'b1;
                    state_d     = SKIP;
                end
            end
            // The start bit is already on the wire while leading zeros are skipped.
            SKIP: begin
                if ((LZ_SUPPRESS != 0) && (digit_idx_q != 3'd0) && (cur_digit == 4'd0)) begin
                    digit_idx_d = digit_idx_q - 3'd1;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                if (tx_if.tx_bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tx_if.tx_bit_end && (tx_if.tx_bit_idx == 4'd8)) begin
                    state_d = STOP;
                end
            end
            // Advance to the next character early; the serializer already holds this byte.
            STOP: begin
                case (sel_q)
                    SEL_DIGIT: begin
                        if (digit_idx_q == 3'd0) begin
                            sel_d = SEL_CR;
                        end else begin
                            digit_idx_d = digit_idx_q - 3'd1;
                        end
                    end
                    SEL_CR:  sel_d = SEL_LF;
                    default: sel_d = SEL_END;
                endcase
                state_d = NEXT;
            end
            NEXT: begin
                if (tx_if.tx_done) begin
                    if (sel_q == SEL_END) begin
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tx_start = 1'b1;
                        state_d  = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHz or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            sel_q       <= SEL_DIGIT;
            digits_q    <= '0;
            digit_idx_q <= '0;
            ready_q     <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            digits_q    <= digits_d;
            digit_idx_q <= digit_idx_d;
            ready_q     <= ready_d;
            dropped_q   <= dropped_d;
        end
    end

endmodule

// File: doc/bcd_uart_reporter.md
BCD_UART_REPORTER -- requirements
Module: bcd_uart_reporter

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 1736, meaning clock cycles per UART bit (57600 bps at 100 MHz).
REQ-002 SHALL have parameter LZ_SUPPRESS, default 1, meaning leading-zero suppression is enabled when 1.
REQ-003 SHALL have port CLK100MHz, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port BCD_IN, input, 32 bits: eight BCD digits, [31:28] most significant, [3:0] least significant.
REQ-006 SHALL have port BCD_VALID, input, 1 bit: a one-cycle strobe that BCD_IN holds a new measurement.
REQ-007 SHALL have port BCD_READY, output, 1 bit: high when a strobe will be accepted.
REQ-008 SHALL have port TXD, output, 1 bit: UART serial output, 8N1, idle high.
REQ-009 SHALL have port DROPPED, output, 1 bit: one-cycle pulse when a strobe arrives while busy.

Function
REQ-010 SHALL accept a measurement when BCD_VALID=1 and BCD_READY=1, latching BCD_IN in that cycle.
REQ-011 SHALL deassert BCD_READY in the cycle after acceptance and hold it low until the final stop bit completes.
REQ-012 SHALL emit one line per accepted measurement: digit characters, then 0x0D, then 0x0A.
REQ-013 SHALL map digit d in 0..9 to ASCII 0x30+d, and d in 10..15 to 0x3F ('?').
REQ-014 SHALL, with LZ_SUPPRESS=1, skip leading 0 digits from digit 7 downward; digit 0 is always sent, so value 0 sends "0".
REQ-015 SHALL, with LZ_SUPPRESS=0, always send all eight digits.
REQ-016 SHALL frame each character as one start bit (0), eight data bits LSB first, and one stop bit (1); each bit is exactly BAUD_DIV cycles.
REQ-017 SHALL drive the start bit of the first character on TXD starting the cycle after acceptance (latency 1).
REQ-018 SHALL send characters back-to-back, with the next start bit immediately following the previous stop bit and no idle gap.
REQ-019 SHALL implement the FSM states IDLE, SKIP, START, DATA, STOP, and NEXT.
- IDLE -> SKIP on accept.
- SKIP advances over suppressed digits, one digit per cycle, then -> START. The cycles spent in SKIP are absorbed into the first start bit, so REQ-017 holds.
- START -> DATA after BAUD_DIV cycles.
- DATA -> STOP after the 8th bit.
- STOP -> NEXT.
- NEXT -> START if characters remain, else -> IDLE.
REQ-020 SHALL, on BCD_VALID during a busy period, ignore the strobe, leave the line in progress unaffected, and pulse DROPPED for one cycle.
REQ-021 SHALL accept a strobe in the same cycle BCD_READY rises; a strobe one cycle earlier is dropped.
REQ-022 SHALL restart the baud counter at 0 at every character start, with no accumulated phase error.
REQ-023 SHALL treat a BCD_IN change after acceptance as having no effect on the line in progress.

Reset
REQ-024 SHALL, while RST_N=0, immediately force TXD=1, BCD_READY=0, DROPPED=0, FSM=IDLE, and clear all counters.
REQ-025 SHALL assert BCD_READY=1 on the first clock edge after RST_N deasserts.
REQ-026 SHALL, on reset mid-character, abandon the line; after reset the next accepted line starts fresh with no partial resend.

Structure
REQ-027 SHALL take from shared package fmeter_pkg the constants ASCII_ZERO=0x30, ASCII_CR=0x0D, ASCII_LF=0x0A, ASCII_BAD=0x3F, the default BAUD_DIV, and the FSM state enum.
REQ-028 SHALL place byte serialization (baud counter, bit counter, shift register) in sub-module uart_tx_byte with a byte/start/done handshake; bcd_uart_reporter sequences characters only.

Verification
REQ-029 SHALL verify: BCD_IN=0x00012345, LZ_SUPPRESS=1 -> TXD decodes "12345\r\n"; 7 characters, 70*1736 cycles from the start bit to final stop end.
REQ-030 SHALL verify: BCD_IN=0x00000000 -> "0\r\n"; with LZ_SUPPRESS=0 -> "00000000\r\n".
REQ-031 SHALL verify: BCD_IN=0x9999999A -> "9999999?\r\n".
REQ-032 SHALL verify: second BCD_VALID 5000 cycles after the first -> DROPPED pulses once, first line intact, BCD_READY high exactly at the last stop bit end.
REQ-033 SHALL verify: RST_N low during the DATA bit 3 of the 2nd character -> TXD=1 within the same cycle, BCD_READY=1 one edge after release, and the next strobe gives a clean full line.
REQ-034 SHALL verify: bit-width check on every bit of a line -> each bit lasts exactly 1736 cycles and the start bit begins 1 cycle after acceptance.
